// File: rtl/cordic_mac_sequencer.sv
// cordic_mac_sequencer: feeds (x, w) pairs to a serial linear-mode CORDIC multiplier and accumulates the products into a neuron sum (MAC_SATURATE_EN selects a clamped out_y_o instead of a wrapped one)
module cordic_mac_sequencer #(
  parameter int DATA_W     = 8,
  parameter int ACC_W      = 16,
  parameter int CORDIC_LAT = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_x_i,
  input  logic [DATA_W-1:0] in_w_i,
  input  logic              in_last_i,
  output logic [DATA_W-1:0] cx0_o,
  output logic [DATA_W-1:0] cy0_o,
  output logic [DATA_W-1:0] cz0_o,
  output logic              cs1_o,
  input  logic [DATA_W-1:0] cyn_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [ACC_W-1:0]  out_acc_o,
  output logic [DATA_W-1:0] out_y_o
);
  localparam int CNT_W = $clog2(CORDIC_LAT + 1);
  localparam logic signed [ACC_W-1:0] Y_MAX = ACC_W'(2 ** (DATA_W - 1) - 1);
  localparam logic signed [ACC_W-1:0] Y_MIN = ~Y_MAX;
  typedef enum logic [1:0] {IDLE, LOAD, ITER, DONE} state_t;
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ACC_W-1:0] acc_q, acc_d, out_acc_q, out_acc_d;
  logic [DATA_W-1:0] cx0_q, cx0_d, cz0_q, cz0_d, out_y_q, out_y_d, acc_narrow;
  logic last_q, last_d, iter_end;
  logic signed [ACC_W-1:0] acc_sum;
  assign acc_sum  = acc_q + {{(ACC_W-DATA_W){cyn_i[DATA_W-1]}}, cyn_i};
  assign iter_end = (state_q == ITER) && (cnt_q == CNT_W'(CORDIC_LAT - 1));
`ifdef MAC_SATURATE_EN
  assign acc_narrow = acc_sum > Y_MAX ? Y_MAX[DATA_W-1:0] :
                      acc_sum < Y_MIN ? Y_MIN[DATA_W-1:0] : acc_sum[DATA_W-1:0];
`else
  assign acc_narrow = acc_sum[DATA_W-1:0];
`endif
  assign in_ready_o  = state_q == IDLE;
  assign out_valid_o = state_q == DONE;
  assign cs1_o       = state_q == LOAD;
  assign cx0_o       = cx0_q;
  assign cy0_o       = '0;
  assign cz0_o       = cz0_q;
  assign out_acc_o   = out_acc_q;
  assign out_y_o     = out_y_q;
  // state and datapath registers; reset aborts any sum in progress
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      cx0_q     <= '0;
      cz0_q     <= '0;
      last_q    <= 1'b0;
      out_acc_q <= '0;
      out_y_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      cx0_q     <= cx0_d;
      cz0_q     <= cz0_d;
      last_q    <= last_d;
      out_acc_q <= out_acc_d;
      out_y_q   <= out_y_d;
    end
  end
  // sequencing: capture operands, strobe the CORDIC, wait its latency, accumulate, present the sum
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    cx0_d     = cx0_q;
    cz0_d     = cz0_q;
    last_d    = last_q;
    out_acc_d = out_acc_q;
    out_y_d   = out_y_q;
    case (state_q)
      IDLE: if (in_valid_i) begin
        cx0_d   = in_x_i;
        cz0_d   = in_w_i;
        last_d  = in_last_i;
        state_d = LOAD;
      end
      LOAD: begin
        cnt_d   = '0;
        state_d = ITER;
      end
      ITER: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (iter_end) begin
          acc_d   = acc_sum;
          state_d = last_q ? DONE : IDLE;
          if (last_q) begin
            out_acc_d = acc_sum;
            out_y_d   = acc_narrow;
          end
        end
      end
      DONE: if (out_ready_i) begin
        acc_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_cordic_mac_sequencer.sv
// tb_cordic_mac_sequencer: table vectors, timing corner cases and random neurons against a sum-of-products model, with a CORDIC stub
module tb_cordic_mac_sequencer;
  localparam int DW = 8, AW = 16, LAT = 7;
  logic clk = 0, rst = 1;
  logic in_valid = 0, in_ready, in_last = 0, cs1, out_valid, out_ready = 0;
  logic [DW-1:0] in_x = 0, in_w = 0, cx0, cy0, cz0, cyn, out_y;
  logic [AW-1:0] out_acc;
  int total = 0, bad = 0, cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  cordic_mac_sequencer #(.DATA_W(DW), .ACC_W(AW), .CORDIC_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .in_valid_i(in_valid), .in_ready_o(in_ready), .in_x_i(in_x),
    .in_w_i(in_w), .in_last_i(in_last), .cx0_o(cx0), .cy0_o(cy0), .cz0_o(cz0), .cs1_o(cs1),
    .cyn_i(cyn), .out_valid_o(out_valid), .out_ready_i(out_ready), .out_acc_o(out_acc), .out_y_o(out_y));
  // CORDIC stub: product is presented only in the cycle LAT after the start strobe, junk otherwise
  logic [LAT-1:0] dly = '0;
  logic signed [DW-1:0] prod_q = '0;
  logic signed [2*DW-1:0] full;
  assign full = $signed(cx0) * $signed(cz0);
  always @(posedge clk) begin
    dly <= {dly[LAT-2:0], cs1};
    if (cs1) prod_q <= DW'(full >>> 6);
  end
  assign cyn = dly[LAT-1] ? prod_q : 8'h5A;
  typedef struct packed {
    logic [2:0] n;
    logic [3:0][7:0] x;
    logic [3:0][7:0] w;
    logic [15:0] acc;
    logic [7:0] yt;
    logic [7:0] ys;
  } vec_t;
  vec_t vecs[6];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  function automatic logic [7:0] narrow(input logic [15:0] acc);
    int s;
    s = $signed(acc);
`ifdef MAC_SATURATE_EN
    if (s > 127) s = 127;
    if (s < -128) s = -128;
`endif
    return s[7:0];
  endfunction
  // reference: each term is the DW-bit product (x*w)>>6, the sum wraps at AW bits
  function automatic logic [15:0] ref_sum(input int n, input logic [3:0][7:0] x, input logic [3:0][7:0] w);
    int sum = 0;
    for (int i = 0; i < n; i++) begin
      int p;
      logic signed [7:0] p8;
      p = ($signed(x[i]) * $signed(w[i])) >>> 6;
      p8 = p[7:0];
      sum += p8;
    end
    return sum[15:0];
  endfunction
  task automatic send(input logic [7:0] x, input logic [7:0] w, input logic last, output int hs);
    int k = 0;
    @(negedge clk);
    while (!in_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("in_ready_wait", {31'd0, in_ready}, 1);
    in_valid = 1; in_x = x; in_w = w; in_last = last; hs = cyc;
    @(posedge clk);
    #1 in_valid = 0;
  endtask
  task automatic recv(input logic [15:0] ea, input logic [7:0] ey, input int hold, input string nm);
    int k = 0;
    @(negedge clk);
    while (!out_valid && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk({nm, "_valid"}, {31'd0, out_valid}, 1);
    repeat (hold) @(negedge clk);
    chk({nm, "_acc"}, {16'd0, out_acc}, {16'd0, ea});
    chk({nm, "_y"}, {24'd0, out_y}, {24'd0, ey});
    out_ready = 1;
    @(posedge clk);
    #1 out_ready = 0;
  endtask
  function automatic vec_t mk(input int n, input int x0, w0, x1, w1, x2, w2, x3, w3, input int acc, yt, ys);
    vec_t v;
    v.n = 3'(n);
    v.x = {8'(x3), 8'(x2), 8'(x1), 8'(x0)};
    v.w = {8'(w3), 8'(w2), 8'(w1), 8'(w0)};
    v.acc = 16'(acc); v.yt = 8'(yt); v.ys = 8'(ys);
    return v;
  endfunction
  initial begin
    int h1, h2, h3;
    vecs[0] = mk(1, 77, 64, 0, 0, 0, 0, 0, 0, 77, 77, 77);
    vecs[1] = mk(3, 77, 64, -32, 64, 40, 32, 0, 0, 65, 65, 65);
    vecs[2] = mk(4, 127, 64, 127, 64, 127, 64, 127, 64, 508, 'hFC, 127);
    vecs[3] = mk(2, -128, 64, -128, 64, 0, 0, 0, 0, 'hFF00, 'h00, 'h80);
    vecs[4] = mk(1, -1, 1, 0, 0, 0, 0, 0, 0, 'hFFFF, 'hFF, 'hFF);
    vecs[5] = mk(2, 100, 127, 50, -64, 0, 0, 0, 0, 'hFF94, 'h94, 'h94);
    #2;
    chk("rst_in_ready", {31'd0, in_ready}, 1);
    chk("rst_cs1", {31'd0, cs1}, 0);
    chk("rst_out_valid", {31'd0, out_valid}, 0);
    chk("rst_out_acc", {16'd0, out_acc}, 0);
    chk("rst_out_y", {24'd0, out_y}, 0);
    chk("rst_cx0", {24'd0, cx0}, 0);
    chk("rst_cz0", {24'd0, cz0}, 0);
    chk("rst_cy0", {24'd0, cy0}, 0);
    repeat (3) @(negedge clk);
    rst = 0;
    // single pair: strobe in cycle 1, sum valid in cycle 9
    send(77, 64, 1, h1);
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      chk($sformatf("t1_cs1_c%0d", k), {31'd0, cs1}, {31'd0, k == 1});
      chk($sformatf("t1_valid_c%0d", k), {31'd0, out_valid}, {31'd0, k == 9});
      if (k == 1) begin
        chk("t1_cx0", {24'd0, cx0}, 77);
        chk("t1_cz0", {24'd0, cz0}, 64);
        chk("t1_cy0", {24'd0, cy0}, 0);
      end
    end
    recv(77, 77, 0, "t1");
    // three pairs: handshakes spaced by LAT+2
    send(77, 64, 0, h1);
    send(-32, 64, 0, h2);
    send(40, 32, 1, h3);
    chk("t2_gap1", h2 - h1, LAT + 2);
    chk("t2_gap2", h3 - h2, LAT + 2);
    recv(65, 65, 0, "t2");
    // table vectors
    foreach (vecs[i]) begin
      for (int t = 0; t < int'(vecs[i].n); t++) send(vecs[i].x[t], vecs[i].w[t], t == int'(vecs[i].n) - 1, h1);
`ifdef MAC_SATURATE_EN
      recv(vecs[i].acc, vecs[i].ys, 0, $sformatf("vec%0d", i));
`else
      recv(vecs[i].acc, vecs[i].yt, 0, $sformatf("vec%0d", i));
`endif
    end
    // backpressure: sum held while out_ready low, acc cleared on release
    send(5, 64, 1, h1);
    recv_wait: begin
      int k = 0;
      @(negedge clk);
      while (!out_valid && k < 100) begin
        @(negedge clk);
        k++;
      end
    end
    for (int k = 0; k < 5; k++) begin
      chk("t4_hold_valid", {31'd0, out_valid}, 1);
      chk("t4_hold_acc", {16'd0, out_acc}, 5);
      chk("t4_hold_in_ready", {31'd0, in_ready}, 0);
      @(negedge clk);
    end
    out_ready = 1;
    @(posedge clk);
    #1 out_ready = 0;
    @(negedge clk);
    chk("t4_in_ready_after", {31'd0, in_ready}, 1);
    chk("t4_valid_after", {31'd0, out_valid}, 0);
    chk("t4_acc_held", {16'd0, out_acc}, 5);
    send(3, 64, 1, h1);
    recv(3, 3, 0, "t4_next");
    // reset during ITER of the second term
    send(20, 64, 0, h1);
    send(30, 64, 0, h1);
    repeat (4) @(negedge clk);
    rst = 1;
    #1;
    chk("t5_cs1", {31'd0, cs1}, 0);
    chk("t5_valid", {31'd0, out_valid}, 0);
    chk("t5_in_ready", {31'd0, in_ready}, 1);
    @(negedge clk);
    rst = 0;
    send(10, 64, 1, h1);
    recv(10, 10, 0, "t5_new");
    // in_valid while busy is ignored
    send(77, 64, 1, h1);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      chk($sformatf("t6_in_ready_c%0d", k), {31'd0, in_ready}, 0);
      chk($sformatf("t6_cx0_c%0d", k), {24'd0, cx0}, 77);
      chk($sformatf("t6_cz0_c%0d", k), {24'd0, cz0}, 64);
      in_valid = 1; in_x = 99; in_w = 99; in_last = 0;
    end
    @(negedge clk);
    in_valid = 0;
    #1;
    recv(77, 77, 0, "t6");
    // random neurons against the model
    for (int r = 0; r < 25; r++) begin
      int n;
      logic [3:0][7:0] x, w;
      logic [15:0] e;
      n = $urandom_range(1, 4);
      for (int t = 0; t < 4; t++) begin
        x[t] = 8'($urandom);
        w[t] = 8'($urandom);
      end
      e = ref_sum(n, x, w);
      for (int t = 0; t < n; t++) send(x[t], w[t], t == n - 1, h1);
      recv(e, narrow(e), $urandom_range(0, 3), $sformatf("rnd%0d", r));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
